// File: rtl/ov_iic_pkg.sv
// rtl/ov_iic_pkg.sv - shared state, status-bit and R/W constants for the SCCB master
package ov_iic_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    TXBYTE,
    RXACK,
    STOP,
    RSTART,
    RXBYTE,
    TXNACK,
    DONE
  } iic_state_e;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_NACK = 2;
  localparam int ST_RD   = 3;
  localparam int ST_OVR  = 4;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/iic_qtick.sv
// rtl/iic_qtick.sv - quarter-SCL-period tick divider with enable and sync clear
module iic_qtick #(
  parameter int QDIV   = 250,
  parameter int QDIV_W = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic       qtick,
  output logic [1:0] quarter
);

  localparam logic [QDIV_W-1:0] CNT_MAX = QDIV_W'(QDIV - 1);

  logic [QDIV_W-1:0] cnt;

  assign qtick = en && (cnt == CNT_MAX);

  always_ff @(posedge clk_sys) begin
    if (rst || clr) begin
      cnt     <= '0;
      quarter <= '0;
    end else if (qtick) begin
      cnt     <= '0;
      quarter <= quarter + 2'd1;
    end else if (en) begin
      cnt <= cnt + QDIV_W'(1);
    end
  end

endmodule

// File: rtl/iic_ctrl.sv
// rtl/iic_ctrl.sv - SCCB/I2C master running one register write or two-phase read per action
module iic_ctrl
  import ov_iic_pkg::*;
#(
  parameter int QDIV   = 250,
  parameter int QDIV_W = 8
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] act_iic_write,
  input  logic [7:0] act_iic_read,
  input  logic [7:0] cfg_iic_devid,
  input  logic [7:0] cfg_iic_addr,
  input  logic [7:0] cfg_iic_wdata,
  output logic [7:0] stu_iic_status,
  output logic [7:0] stu_iic_rdata,
  output logic       iic_scl,
  output logic       iic_sda_oe,
  input  logic       iic_sda_i
);

  iic_state_e state, state_nxt;
  logic       qtick, phase_end, sample_pt, tick_en, accept, act_wr, act_rd;
  logic [1:0] quarter;
  logic [6:0] devid_q;
  logic [7:0] addr_q, wdata_q, shreg;
  logic [2:0] bitcnt;
  logic [1:0] byte_idx;
  logic       op_rd, rd_phase2, gap_done;
  logic       sda_s1, sda_s2;
  logic       scl_nxt, oe_nxt;
  logic [4:0] st;
  logic       unused_devid_lsb;

  assign unused_devid_lsb = cfg_iic_devid[0];
  assign act_wr           = |act_iic_write;
  assign act_rd           = |act_iic_read;
  assign accept           = (state == IDLE) && (act_wr || act_rd);
  assign tick_en          = (state != IDLE) && (state != DONE);
  assign phase_end        = qtick && (quarter == 2'd3);
  assign sample_pt        = qtick && (quarter == 2'd2);
  assign stu_iic_status   = {3'b000, st};

  iic_qtick #(
    .QDIV   (QDIV),
    .QDIV_W (QDIV_W)
  ) u_qtick (
    .clk_sys (clk_sys),
    .rst     (rst),
    .en      (tick_en),
    .clr     (accept),
    .qtick   (qtick),
    .quarter (quarter)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    scl_nxt   = 1'b1;
    oe_nxt    = 1'b0;
    case (state)
      IDLE:   if (accept) state_nxt = START;
      START: begin
        oe_nxt = quarter[1];
        if (phase_end) state_nxt = TXBYTE;
      end
      TXBYTE: begin
        scl_nxt = quarter[1];
        oe_nxt  = ~shreg[7];
        if (phase_end && bitcnt == 3'd0) state_nxt = RXACK;
      end
      RXACK: begin
        scl_nxt = quarter[1];
        if (phase_end) begin
          if (st[ST_NACK])                    state_nxt = STOP;
          else if (rd_phase2)                 state_nxt = RXBYTE;
          else if (byte_idx == 2'd1 && op_rd) state_nxt = STOP;
          else if (byte_idx == 2'd2)          state_nxt = STOP;
          else                                state_nxt = TXBYTE;
        end
      end
      STOP: begin
        scl_nxt = (quarter != 2'd0);
        oe_nxt  = ~quarter[1];
        if (phase_end)
          state_nxt = (op_rd && !rd_phase2 && !st[ST_NACK]) ? RSTART : DONE;
      end
      // First phase is an idle bus-free gap, second is a normal START condition.
      RSTART: begin
        oe_nxt = gap_done && quarter[1];
        if (phase_end && gap_done) state_nxt = TXBYTE;
      end
      RXBYTE: begin
        scl_nxt = quarter[1];
        if (phase_end && bitcnt == 3'd0) state_nxt = TXNACK;
      end
      TXNACK: begin
        scl_nxt = quarter[1];
        if (phase_end) state_nxt = STOP;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      devid_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      shreg     <= '0;
      bitcnt    <= 3'd7;
      byte_idx  <= '0;
      op_rd     <= 1'b0;
      rd_phase2 <= 1'b0;
      gap_done  <= 1'b0;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
    end else begin
      sda_s1 <= iic_sda_i;
      sda_s2 <= sda_s1;
      if (accept) begin
        devid_q   <= cfg_iic_devid[7:1];
        addr_q    <= cfg_iic_addr;
        wdata_q   <= cfg_iic_wdata;
        op_rd     <= !act_wr;
        rd_phase2 <= 1'b0;
        gap_done  <= 1'b0;
        byte_idx  <= '0;
        bitcnt    <= 3'd7;
      end
      case (state)
        START: if (phase_end) shreg <= {devid_q, RW_WRITE};
        TXBYTE: if (phase_end) begin
          shreg  <= {shreg[6:0], 1'b0};
          bitcnt <= bitcnt - 3'd1;
        end
        RXACK: if (phase_end && state_nxt == TXBYTE) begin
          byte_idx <= byte_idx + 2'd1;
          shreg    <= (byte_idx == 2'd0) ? addr_q : wdata_q;
        end
        RSTART: if (phase_end) begin
          gap_done <= 1'b1;
          if (gap_done) begin
            shreg     <= {devid_q, RW_READ};
            rd_phase2 <= 1'b1;
          end
        end
        RXBYTE: begin
          if (sample_pt) shreg  <= {shreg[6:0], sda_s2};
          if (phase_end) bitcnt <= bitcnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      iic_scl       <= 1'b1;
      iic_sda_oe    <= 1'b0;
      st            <= '0;
      stu_iic_rdata <= '0;
    end else begin
      iic_scl    <= scl_nxt;
      iic_sda_oe <= oe_nxt;
      if (act_wr || act_rd) begin
        if (state == IDLE) begin
          st[ST_BUSY] <= 1'b1;
          st[ST_DONE] <= 1'b0;
          st[ST_NACK] <= 1'b0;
          st[ST_OVR]  <= act_wr && act_rd;
        end else begin
          st[ST_OVR] <= 1'b1;
        end
      end
      if (state == RXACK && sample_pt && sda_s2) st[ST_NACK] <= 1'b1;
      if (state == DONE) begin
        st[ST_BUSY] <= 1'b0;
        st[ST_DONE] <= 1'b1;
        st[ST_RD]   <= op_rd;
        if (op_rd && !st[ST_NACK]) stu_iic_rdata <= shreg;
      end
    end
  end

endmodule
